// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state type, word-index constant and access error check for dmem_arbiter.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam int WORD_LSB = 2;
  function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] words);
    return (addr[WORD_LSB-1:0] != '0) || ({{WORD_LSB{1'b0}}, addr[31:WORD_LSB]} >= words);
  endfunction
endpackage

// File: rtl/dmem_arbiter_rr.sv
// rr_arbiter: one-hot round-robin grant, searching upward from ptr with wrap-around.
module rr_arbiter #(
  parameter int N = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);
  int k;
  logic found;
  assign any = |req;
  always_comb begin
    grant = '0;
    idx = '0;
    found = 1'b0;
    k = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!found && req[k]) begin
        found = 1'b1;
        grant[k] = 1'b1;
        idx = PW'(k);
      end
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of the single-port data memory, one access per
// accept/access/response sequence.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int DATA_W = 32,
  parameter int MEM_WORDS = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_write,
  input  logic [N_REQ*DATA_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        resp_valid,
  input  logic [N_REQ-1:0]        resp_ready,
  output logic [DATA_W-1:0]       resp_rdata,
  output logic                    resp_err,
  output logic                    mem_enable,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [DATA_W-1:0]       mem_address,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  state_t state, state_n;
  logic [PW-1:0] ptr, gidx, g_n;
  logic [N_REQ-1:0] grant;
  logic any, l_write, err, acc_ok;
  logic [DATA_W-1:0] l_addr, l_wdata;
  rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
    .req(req_valid), .ptr(ptr), .grant(grant), .idx(g_n), .any(any)
  );
  assign err = addr_err(l_addr, 32'(MEM_WORDS));
  // Erroneous accesses never touch the memory, so no side effect and no X read-back.
  assign acc_ok = (state == ACCESS) && !err;
  assign mem_enable = acc_ok;
  assign mem_read = acc_ok && !l_write;
  assign mem_write = acc_ok && l_write;
  assign mem_address = acc_ok ? l_addr : '0;
  assign mem_wdata = acc_ok ? l_wdata : '0;
  assign req_ready = (state == IDLE) ? grant : '0;
  assign resp_valid = (state == RESP) ? (N_REQ'(1) << gidx) : '0;
  always_comb begin
    state_n = (state == IDLE) ? (any ? ACCESS : IDLE) :
              (state == ACCESS) ? RESP :
              (resp_ready[gidx] ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      gidx <= '0;
      l_write <= 1'b0;
      l_addr <= '0;
      l_wdata <= '0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && any) begin
        gidx <= g_n;
        ptr <= (g_n == PW'(N_REQ - 1)) ? '0 : g_n + 1'b1;
        l_write <= req_write[g_n];
        l_addr <= req_addr[g_n*DATA_W +: DATA_W];
        l_wdata <= req_wdata[g_n*DATA_W +: DATA_W];
      end
      if (state == ACCESS) begin
        resp_rdata <= mem_read ? mem_rdata : '0;
        resp_err <= err;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed cycle-by-cycle vectors plus backpressure and reset-in-RESP sequences.
module tb_dmem_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] req_valid = '0, req_write = '0, req_ready, resp_valid, resp_ready = '0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [31:0] resp_rdata, mem_address, mem_wdata, mem_rdata;
  logic resp_err, mem_enable, mem_read, mem_write;
  logic [31:0] mem [1024];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_enable(mem_enable), .mem_read(mem_read),
    .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_address[11:2]];
  always @(posedge clk) if (mem_enable && mem_write) mem[mem_address[11:2]] <= mem_wdata;

  typedef struct {
    logic [1:0] rv, rw, rr;
    logic [31:0] a0, a1, wd;
    logic [1:0] rdy, rsv;
    logic men, mrd, mwr;
    logic [31:0] maddr;
    logic err;
    logic [31:0] rdata;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic add(input logic [1:0] rv, rw, input logic [31:0] a0, a1, wd,
                     input logic [1:0] rdy, rsv, input logic men, mrd, mwr,
                     input logic [31:0] maddr, input logic err, input logic [31:0] rdata);
    vec_t v;
    v.rv = rv; v.rw = rw; v.rr = 2'b11; v.a0 = a0; v.a1 = a1; v.wd = wd;
    v.rdy = rdy; v.rsv = rsv; v.men = men; v.mrd = mrd; v.mwr = mwr;
    v.maddr = maddr; v.err = err; v.rdata = rdata;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [1:0] rv, rw, rr, input logic [31:0] a0, a1, wd);
    req_valid = rv; req_write = rw; resp_ready = rr;
    req_addr = {a1, a0}; req_wdata = {wd, wd};
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0] = 32'hCAFE0000;
    //  rv    rw    a0     a1      wd            rdy   rsv  men mrd mwr maddr err rdata
    add(2'b01, 2'b01, 32'h10, 0, 32'hDEADBEEF, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
    add(2'b00, 2'b00, 0, 0, 32'hDEADBEEF, 2'b00, 2'b00, 1, 0, 1, 32'h10, 0, 0);
    add(2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0);
    add(2'b10, 2'b00, 0, 32'h10, 0, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0);
    add(2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0, 32'h10, 0, 0);
    add(2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b10, 0, 0, 0, 0, 0, 32'hDEADBEEF);
    for (int r = 0; r < 2; r++) begin
      add(2'b11, 2'b00, 32'h10, 32'h10, 0, r ? 2'b10 : 2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
      add(2'b11, 2'b00, 32'h10, 32'h10, 0, 2'b00, 2'b00, 1, 1, 0, 32'h10, 0, 0);
      add(2'b11, 2'b00, 32'h10, 32'h10, 0, 2'b00, r ? 2'b10 : 2'b01, 0, 0, 0, 0, 0, 32'hDEADBEEF);
    end
    add(2'b01, 2'b00, 32'h13, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
    add(2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    add(2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0, 1, 0);
    add(2'b10, 2'b10, 0, 32'h1000, 32'h12345678, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0);
    add(2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    add(2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b10, 0, 0, 0, 0, 1, 0);
    add(2'b01, 2'b00, 32'h0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
    add(2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0, 32'h0, 0, 0);
    add(2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0, 0, 32'hCAFE0000);

    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_mem_ctl", {29'd0, mem_enable, mem_read, mem_write}, 0);
    chk("rst_resp", {31'd0, resp_err} | resp_rdata, 0);
    chk("rst_mem_addr", mem_address | mem_wdata, 0);
    reset = 1'b0;

    foreach (vecs[n]) begin
      @(negedge clk);
      drive(vecs[n].rv, vecs[n].rw, vecs[n].rr, vecs[n].a0, vecs[n].a1, vecs[n].wd);
      #1;
      chk($sformatf("v%0d_req_ready", n), 32'(req_ready), 32'(vecs[n].rdy));
      chk($sformatf("v%0d_resp_valid", n), 32'(resp_valid), 32'(vecs[n].rsv));
      chk($sformatf("v%0d_mem_ctl", n), {29'd0, mem_enable, mem_read, mem_write},
          {29'd0, vecs[n].men, vecs[n].mrd, vecs[n].mwr});
      if (vecs[n].men) chk($sformatf("v%0d_mem_addr", n), mem_address, vecs[n].maddr);
      if (vecs[n].mwr) chk($sformatf("v%0d_mem_wdata", n), mem_wdata, vecs[n].wd);
      if (vecs[n].rsv != 0) begin
        chk($sformatf("v%0d_resp_err", n), 32'(resp_err), 32'(vecs[n].err));
        chk($sformatf("v%0d_resp_rdata", n), resp_rdata, vecs[n].rdata);
      end
    end

    // Backpressure: req0 load of 0x10 held in RESP for 5 cycles while both requesters wait.
    @(negedge clk); drive(2'b01, 2'b00, 2'b00, 32'h10, 32'h10, 0); #1;
    chk("bp_accept", 32'(req_ready), 32'h1);
    @(negedge clk); drive(2'b11, 2'b00, 2'b00, 32'h10, 32'h10, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      chk($sformatf("bp%0d_resp_valid", c), 32'(resp_valid), 32'h1);
      chk($sformatf("bp%0d_resp_rdata", c), resp_rdata, 32'hDEADBEEF);
      chk($sformatf("bp%0d_req_ready", c), 32'(req_ready), 0);
    end
    resp_ready = 2'b01;
    @(negedge clk); drive(2'b01, 2'b00, 2'b00, 32'h10, 32'h10, 0); #1;
    chk("bp_release_idle", 32'(req_ready), 32'h1);
    chk("bp_release_resp", 32'(resp_valid), 0);

    // Reset while in RESP: response dropped, pointer back to 0 (would otherwise be 1).
    @(negedge clk); drive(2'b00, 2'b00, 2'b00, 0, 0, 0);
    @(negedge clk); #1;
    chk("rr_in_resp", 32'(resp_valid), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(2'b11, 2'b00, 2'b00, 32'h10, 32'h10, 0); #1;
    chk("rst_resp_dropped", 32'(resp_valid), 0);
    chk("rst_ptr_zero", 32'(req_ready), 32'h1);
    chk("rst_rdata_clr", resp_rdata, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
